rf_write_arbiter: RTL and testbench

- Shares the single write port of the 8x16 register file (3-bit write select, write data, write enable) between two writeback requesters: req0 (ALU path) and req1 (memory/load path).
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Contains a clear sequencer that, on command, writes zero to r0..r7 over 8 consecutive cycles.
- Sits between the writeback stage and the register file. Its registered outputs drive the register file's write port directly.

---
 rtl/rf_write_arbiter_pkg.sv | 13 +
 rtl/rf_write_arbiter_rr.sv | 22 ++
 rtl/rf_write_arbiter.sv | 106 ++++++++++
 tb/tb_rf_write_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared encodings and sizes for the register-file write arbiter.
// state_t uses a 2-bit code; only IDLE and CLEAR are legal.
package rf_write_arbiter_pkg;

  localparam int unsigned REG_SEL_W = 3;
  localparam int unsigned NREGS     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CLEAR = 2'b01
  } state_t;

endpackage

// File: rtl/rf_write_arbiter_rr.sv
// Two-way round-robin arbiter.
// ptr=0 favours requester 0 on contention. ptr_next points at the loser of a grant.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] grant,
  output logic       ptr_next
);

  always_comb begin
    grant    = 2'b00;
    ptr_next = ptr;
    if (en) begin
      if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
      else                grant = valid;
    end
    if (grant[0])      ptr_next = 1'b1;
    else if (grant[1]) ptr_next = 1'b0;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between the ALU and load writeback paths.
// Also runs an 8-cycle clear sequence that zeroes r0..r7.
module rf_write_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = rf_write_arbiter_pkg::NREGS
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      init,
  input  logic                                      req0_valid,
  input  logic [rf_write_arbiter_pkg::REG_SEL_W-1:0] req0_sel,
  input  logic [WIDTH-1:0]                          req0_data,
  output logic                                      req0_ready,
  input  logic                                      req1_valid,
  input  logic [rf_write_arbiter_pkg::REG_SEL_W-1:0] req1_sel,
  input  logic [WIDTH-1:0]                          req1_data,
  output logic                                      req1_ready,
  output logic [rf_write_arbiter_pkg::REG_SEL_W-1:0] writeRegSel,
  output logic [WIDTH-1:0]                          writeData,
  output logic                                      writeEn,
  output logic                                      busy,
  output logic                                      err
);

  import rf_write_arbiter_pkg::*;

  state_t               state;
  logic [REG_SEL_W-1:0] cnt;
  logic                 ptr;
  logic                 ptr_next;
  logic [1:0]           grant;
  logic                 arb_en;

  // Arbitration is only open in IDLE with no clear request and out of reset.
  always_comb begin
    arb_en = !rst && (state == IDLE) && !init;
  end

  rr_arbiter2 u_arb (
    .valid    ({req1_valid, req0_valid}),
    .ptr      (ptr),
    .en       (arb_en),
    .grant    (grant),
    .ptr_next (ptr_next)
  );

  always_comb begin
    req0_ready = grant[0];
    req1_ready = grant[1];
  end

  always_comb begin
    err = (^{rst, init, req0_valid, req0_sel, req0_data,
             req1_valid, req1_sel, req1_data} === 1'bx)
          || !(state inside {IDLE, CLEAR});
  end

  // FSM, clear counter, pointer and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ptr         <= 1'b0;
      writeEn     <= 1'b0;
      writeRegSel <= '0;
      writeData   <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          writeEn <= 1'b0;
          busy    <= 1'b0;
          if (init) begin
            state <= CLEAR;
            cnt   <= '0;
          end else begin
            ptr <= ptr_next;
            if (grant[0]) begin
              writeEn     <= 1'b1;
              writeRegSel <= req0_sel;
              writeData   <= req0_data;
            end else if (grant[1]) begin
              writeEn     <= 1'b1;
              writeRegSel <= req1_sel;
              writeData   <= req1_data;
            end
          end
        end
        CLEAR: begin
          writeEn     <= 1'b1;
          writeRegSel <= cnt;
          writeData   <= '0;
          busy        <= 1'b1;
          cnt         <= cnt + REG_SEL_W'(1);
          if (cnt == REG_SEL_W'(NREGS - 1)) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          writeEn <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter.
// A behavioural model, directed scenarios and a randomized phase, plus a register file fed by the DUT.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init = 1'b0;
  logic        req0_valid = 1'b0;
  logic [2:0]  req0_sel = 3'd0;
  logic [15:0] req0_data = 16'h0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [2:0]  req1_sel = 3'd0;
  logic [15:0] req1_data = 16'h0;
  logic        req1_ready;
  logic [2:0]  writeRegSel;
  logic [15:0] writeData;
  logic        writeEn;
  logic        busy;
  logic        err;

  rf_write_arbiter #(.WIDTH(16), .NREGS(8)) dut (
    .clk(clk), .rst(rst), .init(init),
    .req0_valid(req0_valid), .req0_sel(req0_sel), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_sel(req1_sel), .req1_data(req1_data), .req1_ready(req1_ready),
    .writeRegSel(writeRegSel), .writeData(writeData), .writeEn(writeEn),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Register file driven by the DUT, and the one the model expects.
  logic [15:0] rf  [8];
  logic [15:0] mrf [8];

  // Model: clear_left counts the remaining CLEAR-state cycles; favour is whose turn it is on contention.
  bit          started = 1'b0;
  int          clear_left = 0;
  bit          favour = 1'b0;
  logic        exp_en = 1'b0;
  logic [2:0]  exp_sel = 3'd0;
  logic [15:0] exp_data = 16'h0;
  logic        exp_busy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] want_grant();
    logic open;
    open = !rst && (clear_left == 0) && !init;
    want_grant[0] = open && req0_valid && (!req1_valid || favour == 1'b0);
    want_grant[1] = open && req1_valid && (!req0_valid || favour == 1'b1);
  endfunction

  always @(posedge clk) begin : model_step
    logic [1:0] g;
    g = want_grant();
    if (started) begin
      if (writeEn) rf[writeRegSel] = writeData;
      if (exp_en)  mrf[exp_sel]    = exp_data;
    end
    if (rst) begin
      exp_en = 1'b0; exp_sel = 3'd0; exp_data = 16'h0; exp_busy = 1'b0;
      favour = 1'b0; clear_left = 0; started = 1'b1;
    end else if (clear_left > 0) begin
      exp_en = 1'b1; exp_sel = 3'(8 - clear_left); exp_data = 16'h0; exp_busy = 1'b1;
      clear_left--;
    end else if (init) begin
      exp_en = 1'b0; exp_busy = 1'b0; clear_left = 8;
    end else if (g[0]) begin
      exp_en = 1'b1; exp_sel = req0_sel; exp_data = req0_data; exp_busy = 1'b0; favour = 1'b1;
    end else if (g[1]) begin
      exp_en = 1'b1; exp_sel = req1_sel; exp_data = req1_data; exp_busy = 1'b0; favour = 1'b0;
    end else begin
      exp_en = 1'b0; exp_busy = 1'b0;
    end
  end

  always @(negedge clk) begin : compare
    logic [1:0] g;
    g = want_grant();
    chk("req0_ready", 32'(req0_ready), 32'(g[0]));
    chk("req1_ready", 32'(req1_ready), 32'(g[1]));
    if (started) begin
      chk("writeEn",     32'(writeEn),     32'(exp_en));
      chk("writeRegSel", 32'(writeRegSel), 32'(exp_sel));
      chk("writeData",   32'(writeData),   32'(exp_data));
      chk("busy",        32'(busy),        32'(exp_busy));
      chk("err",         32'(err),         32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] base);
    for (int i = 0; i < 8; i++) begin
      req0_valid = 1'b1; req0_sel = 3'(i); req0_data = base + 16'(i + 1);
      step();
    end
    req0_valid = 1'b0;
    step();
    step();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin rf[i] = 16'h0; mrf[i] = 16'h0; end

    // Reset for two cycles, then idle.
    step(); step();
    @(negedge clk);
    chk("pin_rst_writeEn", 32'(writeEn), 32'd0);
    chk("pin_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step(); step(); step();
    @(negedge clk);
    chk("pin_idle_writeEn", 32'(writeEn), 32'd0);

    // Single requester.
    step();
    req0_valid = 1'b1; req0_sel = 3'd3; req0_data = 16'hBEEF;
    @(negedge clk);
    chk("pin_single_ready", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("pin_single_en", 32'(writeEn), 32'd1);
    chk("pin_single_sel", 32'(writeRegSel), 32'd3);
    chk("pin_single_data", 32'(writeData), 32'hBEEF);
    step(); step();
    chk("pin_r3", 32'(rf[3]), 32'hBEEF);

    // Reset to bring the pointer back to req0, then contention.
    rst = 1'b1; step(); rst = 1'b0;
    req0_valid = 1'b1; req0_sel = 3'd1; req0_data = 16'h1111;
    req1_valid = 1'b1; req1_sel = 3'd2; req1_data = 16'h2222;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      @(negedge clk);
      if (i < 4) chk("pin_cont_ready0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i > 0) begin
        chk("pin_cont_en", 32'(writeEn), 32'd1);
        chk("pin_cont_sel", 32'(writeRegSel), (i % 2 == 1) ? 32'd1 : 32'd2);
      end
      step();
    end

    // Same destination from both requesters.
    req0_valid = 1'b1; req0_sel = 3'd5; req0_data = 16'hAAAA;
    req1_valid = 1'b1; req1_sel = 3'd5; req1_data = 16'h5555;
    @(negedge clk);
    chk("pin_coll_first", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    step();
    req1_valid = 1'b0;
    step(); step();
    chk("pin_r5", 32'(rf[5]), 32'h5555);

    // Clear with req1 waiting.
    load(16'h1000);
    req1_valid = 1'b1; req1_sel = 3'd6; req1_data = 16'h6666;
    init = 1'b1;
    @(negedge clk);
    chk("pin_clr_ready_init", 32'(req1_ready), 32'd0);
    step();
    init = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("pin_clr_ready1", 32'(req1_ready), (k == 8) ? 32'd1 : 32'd0);
      chk("pin_clr_busy", 32'(busy), (k >= 1) ? 32'd1 : 32'd0);
      if (k >= 1) begin
        chk("pin_clr_sel", 32'(writeRegSel), 32'(k - 1));
        chk("pin_clr_data", 32'(writeData), 32'd0);
      end
      step();
    end
    req1_valid = 1'b0;
    for (int i = 0; i < 8; i++) chk("pin_clr_zero", 32'(rf[i]), 32'd0);
    step();
    chk("pin_r6_after", 32'(rf[6]), 32'h6666);

    // Reset after the third clear write.
    load(16'h2000);
    init = 1'b1;
    step();
    init = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    @(negedge clk);
    chk("pin_mid_sel", 32'(writeRegSel), 32'd2);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("pin_mid_en", 32'(writeEn), 32'd0);
    chk("pin_mid_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++)
      chk("pin_mid_reg", 32'(rf[i]), (i < 3) ? 32'd0 : 32'(16'h2000 + 16'(i + 1)));

    // Randomized traffic; requesters hold until granted.
    for (int n = 0; n < 3000; n++) begin
      logic t0, t1;
      @(negedge clk);
      t0 = req0_ready; t1 = req1_ready;
      step();
      rst  = ($urandom_range(63) == 0);
      init = ($urandom_range(15) == 0);
      if (!req0_valid || t0) begin
        req0_valid = 1'($urandom_range(1)); req0_sel = 3'($urandom); req0_data = 16'($urandom);
      end
      if (!req1_valid || t1) begin
        req1_valid = 1'($urandom_range(1)); req1_sel = 3'($urandom); req1_data = 16'($urandom);
      end
    end
    rst = 1'b0; init = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 12; i++) step();
    for (int i = 0; i < 8; i++) chk("final_regfile", 32'(rf[i]), 32'(mrf[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
